// File: rtl/fetch_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr_D;
  logic [31:0] pc_plus4_D;
  logic        valid_D;

  modport master (
    input  stall, redirect, redirect_pc, halt, imem_ready, imem_rdata,
    output imem_addr, imem_req, instr_D, pc_plus4_D, valid_D
  );

  modport slave (
    output stall, redirect, redirect_pc, halt, imem_ready, imem_rdata,
    input  imem_addr, imem_req, instr_D, pc_plus4_D, valid_D
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch with IF/ID register, one-entry skid buffer for decode
// stalls, redirect flush and a permanent halt state.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic {FETCH, HALTED} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] buf_instr;
  logic [XLEN-1:0] buf_pc4;
  logic            buf_valid;
  logic            accept;

  // Request is never a function of imem_ready; a full buffer blocks new fetches.
  assign bus.imem_addr = pc;
  assign bus.imem_req  = (state == FETCH) && !buf_valid;
  assign accept        = bus.imem_req && bus.imem_ready;
  assign pc_plus4      = pc + PC_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      buf_instr      <= '0;
      buf_pc4        <= '0;
      buf_valid      <= 1'b0;
      bus.instr_D    <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
    end else if (state == HALTED) begin
      bus.instr_D    <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
      buf_valid      <= 1'b0;
    end else if (bus.halt) begin
      state          <= HALTED;
      bus.instr_D    <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
      buf_valid      <= 1'b0;
    end else if (bus.redirect) begin
      // Any word accepted this cycle belongs to the squashed path.
      pc             <= bus.redirect_pc & ALIGN_MASK;
      bus.instr_D    <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
      buf_valid      <= 1'b0;
    end else if (bus.stall) begin
      if (accept) begin
        buf_instr <= bus.imem_rdata;
        buf_pc4   <= pc_plus4;
        buf_valid <= 1'b1;
        pc        <= pc_plus4;
      end
    end else if (buf_valid) begin
      bus.instr_D    <= buf_instr;
      bus.pc_plus4_D <= buf_pc4;
      bus.valid_D    <= 1'b1;
      buf_valid      <= 1'b0;
    end else if (accept) begin
      bus.instr_D    <= bus.imem_rdata;
      bus.pc_plus4_D <= pc_plus4;
      bus.valid_D    <= 1'b1;
      pc             <= pc_plus4;
    end else begin
      bus.instr_D    <= '0;
      bus.pc_plus4_D <= '0;
      bus.valid_D    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns addr ^ 32'hA5A5_0000.
module tb_fetch_stage;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fetch_if bus();

  fetch_stage #(.RESET_PC(32'h0040_0000)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stateless instruction memory: data is valid whenever the TB raises imem_ready.
  assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc4,
                       input logic vld);
    chk({tag, ".instr"}, bus.instr_D, instr);
    chk({tag, ".pc4"},   bus.pc_plus4_D, pc4);
    chk({tag, ".valid"}, 32'(bus.valid_D), 32'(vld));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    bus.imem_ready = 1'b1;

    // Reset values
    tick();
    chk("rst.addr", bus.imem_addr, 32'h0040_0000);
    chk("rst.req", 32'(bus.imem_req), 32'd1);
    chk_d("rst", 32'h0, 32'h0, 1'b0);

    // Zero-wait stream
    rst = 1'b0;
    tick(); chk_d("s0", 32'hA5E5_0000, 32'h0040_0004, 1'b1);
    chk("s0.addr", bus.imem_addr, 32'h0040_0004);
    tick(); chk_d("s1", 32'hA5E5_0004, 32'h0040_0008, 1'b1);
    tick(); chk_d("s2", 32'hA5E5_0008, 32'h0040_000C, 1'b1);

    // Wait states: ready every third cycle
    bus.imem_ready = 1'b0;
    tick(); chk_d("w0", 32'h0, 32'h0, 1'b0); chk("w0.addr", bus.imem_addr, 32'h0040_000C);
    tick(); chk_d("w1", 32'h0, 32'h0, 1'b0); chk("w1.addr", bus.imem_addr, 32'h0040_000C);
    bus.imem_ready = 1'b1;
    tick(); chk_d("w2", 32'hA5E5_000C, 32'h0040_0010, 1'b1);
    bus.imem_ready = 1'b0;
    tick(); chk_d("w3", 32'h0, 32'h0, 1'b0);
    tick(); chk_d("w4", 32'h0, 32'h0, 1'b0); chk("w4.addr", bus.imem_addr, 32'h0040_0010);
    bus.imem_ready = 1'b1;
    tick(); chk_d("w5", 32'hA5E5_0010, 32'h0040_0014, 1'b1);

    // Stall four cycles with memory ready: one word skids into the buffer
    bus.stall = 1'b1;
    tick(); chk_d("st0", 32'hA5E5_0010, 32'h0040_0014, 1'b1);
    chk("st0.req", 32'(bus.imem_req), 32'd0);
    chk("st0.addr", bus.imem_addr, 32'h0040_0018);
    tick(); chk_d("st1", 32'hA5E5_0010, 32'h0040_0014, 1'b1); chk("st1.req", 32'(bus.imem_req), 32'd0);
    tick(); chk("st2.req", 32'(bus.imem_req), 32'd0);
    tick(); chk_d("st3", 32'hA5E5_0010, 32'h0040_0014, 1'b1);
    chk("st3.addr", bus.imem_addr, 32'h0040_0018);
    bus.stall = 1'b0;
    tick(); chk_d("rl0", 32'hA5E5_0014, 32'h0040_0018, 1'b1);
    chk("rl0.req", 32'(bus.imem_req), 32'd1);
    tick(); chk_d("rl1", 32'hA5E5_0018, 32'h0040_001C, 1'b1);

    // Redirect while a word is accepted: word dropped, target aligned
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0103;
    tick(); chk_d("rd0", 32'h0, 32'h0, 1'b0); chk("rd0.addr", bus.imem_addr, 32'h0040_0100);
    bus.redirect = 1'b0;
    tick(); chk_d("rd1", 32'hA5E5_0100, 32'h0040_0104, 1'b1);

    // Redirect with stall and a full buffer
    bus.stall = 1'b1;
    tick(); chk_d("rs0", 32'hA5E5_0100, 32'h0040_0104, 1'b1); chk("rs0.req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0040_0200;
    tick(); chk_d("rs1", 32'h0, 32'h0, 1'b0);
    chk("rs1.req", 32'(bus.imem_req), 32'd1);
    chk("rs1.addr", bus.imem_addr, 32'h0040_0200);
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    tick(); chk_d("rs2", 32'hA5E5_0200, 32'h0040_0204, 1'b1);
    tick(); chk_d("rs3", 32'hA5E5_0204, 32'h0040_0208, 1'b1);

    // Halt beats a simultaneous redirect; later redirects are ignored
    bus.halt = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_1000;
    tick(); chk_d("h0", 32'h0, 32'h0, 1'b0);
    chk("h0.req", 32'(bus.imem_req), 32'd0);
    chk("h0.addr", bus.imem_addr, 32'h0040_0208);
    bus.halt = 1'b0;
    tick(); chk("h1.addr", bus.imem_addr, 32'h0040_0208);
    bus.redirect = 1'b0;
    tick(); chk_d("h2", 32'h0, 32'h0, 1'b0); chk("h2.req", 32'(bus.imem_req), 32'd0);
    tick(); chk_d("h3", 32'h0, 32'h0, 1'b0);

    // Asynchronous reset restores fetch
    #2 rst = 1'b1;
    #1 chk("ar.addr", bus.imem_addr, 32'h0040_0000);
    chk("ar.req", 32'(bus.imem_req), 32'd1);
    tick(); rst = 1'b0;
    tick(); chk_d("ar1", 32'hA5E5_0000, 32'h0040_0004, 1'b1);

    // PC wrap at the top of the address space
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick(); chk_d("wr0", 32'h0, 32'h0, 1'b0); chk("wr0.addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.redirect = 1'b0;
    tick(); chk_d("wr1", 32'h5A5A_FFFC, 32'h0000_0000, 1'b1);
    chk("wr1.addr", bus.imem_addr, 32'h0000_0000);
    tick(); chk_d("wr2", 32'hA5A5_0000, 32'h0000_0004, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
